// File: rtl/req_responder.sv
// Responder end of the irdy/trdy request/response network: serves type-0 requests in order,
// one type-1 response per request after LAT cycles. Optional stats via XMAS_RSP_STATS_EN.
module req_responder #(
  parameter int DEPTH = 2,
  parameter int LAT   = 1,
  parameter int LAT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i0_irdy_i,
  output logic       i0_trdy_o,
  input  logic [1:0] i0_data_type_i,
  output logic       o0_irdy_o,
  input  logic       o0_trdy_i,
  output logic [1:0] o0_data_type_o,
  output logic       busy_o
`ifdef XMAS_RSP_STATS_EN
  ,
  output logic [CNT_W-1:0] req_cnt_o,
  output logic [CNT_W-1:0] rsp_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             accept, req_acc, drop_acc, rsp_hs;

  assign i0_trdy_o = !rst && (occ_q != OCC_W'(DEPTH));
  assign accept    = i0_irdy_i && i0_trdy_o;
  assign req_acc   = accept && (i0_data_type_i == 2'd0);
  assign drop_acc  = accept && (i0_data_type_i != 2'd0);
  assign rsp_hs    = (state_q == SEND) && o0_trdy_i;
  assign busy_o    = (state_q != IDLE) || (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    if (req_acc && !rsp_hs) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!req_acc && rsp_hs) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    o0_irdy_o      = 1'b0;
    o0_data_type_o = 2'd0;
    case (state_q)
      IDLE: begin
        if (req_acc || occ_q != '0) begin
          cnt_d   = LAT_W'(LAT);
          state_d = (LAT == 0) ? SEND : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        o0_irdy_o      = 1'b1;
        o0_data_type_o = 2'd1;
        if (o0_trdy_i) begin
          // Latency for the next response restarts from this handshake.
          if (occ_d != '0) begin
            cnt_d   = LAT_W'(LAT);
            state_d = (LAT == 0) ? SEND : WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef XMAS_RSP_STATS_EN
  logic [CNT_W-1:0] req_cnt_q, rsp_cnt_q, drop_cnt_q;

  // Statistics saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (req_acc && req_cnt_q != '1) req_cnt_q <= req_cnt_q + CNT_W'(1);
      if (rsp_hs && rsp_cnt_q != '1) rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
      if (drop_acc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign req_cnt_o  = req_cnt_q;
  assign rsp_cnt_o  = rsp_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
